// File: rtl/ans_cum_table.sv
// ans_cum_table
//   Cumulative-frequency table builder for the ANS coder. A start request
//   snapshots the per-symbol counts. The prefix-sum table is then built one
//   entry per cycle, 16 cycles in all. Two combinational lookups read the
//   finished table: per-symbol count/cumulative for the encoder and
//   slot-to-symbol for the decoder.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   counts_unpacked  : symbol i count at [i*CNT_WIDTH +: CNT_WIDTH]
//   start            : build request, accepted only when not busy
//   busy             : table build in progress
//   table_vld        : a completed table is available
//   total_count      : sum of all snapshot counts (registered)
//   sym              : encoder lookup symbol
//   s_count          : snapshot count of sym
//   s_cumulative     : cumulative value of sym
//   slot             : decoder lookup slot
//   slot_sym         : symbol whose [cum, cum+count) range holds slot
//   slot_err         : no valid table, or slot >= total_count
//   dbg_state        : current FSM state (debug visibility)
//
// Handshake: start is a level sampled on the rising edge. It is consumed on
// any edge where the block is idle or done. It is dropped without queuing
// while busy.
module ans_cum_table #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4,
  parameter int CUM_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [(1<<SYM_WIDTH)*CNT_WIDTH-1:0]   counts_unpacked,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  table_vld,
  output logic [CUM_WIDTH-1:0]                  total_count,
  input  logic [SYM_WIDTH-1:0]                  sym,
  output logic [CNT_WIDTH-1:0]                  s_count,
  output logic [CUM_WIDTH-1:0]                  s_cumulative,
  input  logic [CUM_WIDTH-1:0]                  slot,
  output logic [SYM_WIDTH-1:0]                  slot_sym,
  output logic                                  slot_err,
  output logic [1:0]                            dbg_state
);

  localparam int NUM_SYM = 1 << SYM_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt [NUM_SYM];
  logic [CUM_WIDTH-1:0] cum [NUM_SYM];
  logic [CUM_WIDTH-1:0] acc;
  logic [SYM_WIDTH-1:0] idx;
  logic [SYM_WIDTH-1:0] slot_hit;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      idx         <= '0;
      total_count <= '0;
      busy        <= 1'b0;
      table_vld   <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) begin
        cnt[i] <= '0;
        cum[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_SYM; i++) begin
              cnt[i] <= counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
            end
            acc       <= '0;
            idx       <= '0;
            table_vld <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          cum[idx] <= acc;
          acc      <= acc + CUM_WIDTH'(cnt[idx]);
          idx      <= idx + SYM_WIDTH'(1);
          // Last entry: the total is the running sum including this count.
          if (idx == {SYM_WIDTH{1'b1}}) begin
            total_count <= acc + CUM_WIDTH'(cnt[idx]);
            busy        <= 1'b0;
            table_vld   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Encoder lookup: plain muxes over the registered table.
  assign s_count      = cnt[sym];
  assign s_cumulative = cum[sym];

  // Decoder lookup: ranges of non-zero symbols are disjoint, so at most one
  // entry matches. The compare is one bit wider so cum+cnt cannot wrap.
  always_comb begin
    slot_hit = '0;
    for (int s = 0; s < NUM_SYM; s++) begin
      if ((cnt[s] != '0) && (slot >= cum[s]) &&
          ({1'b0, slot} < ({1'b0, cum[s]} + (CUM_WIDTH+1)'(cnt[s])))) begin
        slot_hit = SYM_WIDTH'(s);
      end
    end
  end

  assign slot_err = !table_vld || (slot >= total_count);
  assign slot_sym = slot_err ? '0 : slot_hit;

endmodule

// File: doc/ans_cum_table.md
# ans_cum_table

Cumulative-frequency table builder for the ANS coder. It snapshots the 16 loaded symbol counts from the count loader and builds the prefix-sum table over 16 cycles. It then serves two combinational lookups:
- the encoder's per-symbol `s_count`, `s_cumulative` and `total_count` inputs;
- the decoder's slot-to-symbol lookup.

It sits between the count loader and the encoder/decoder pair.

## Interface
Parameters:
- `SYM_WIDTH`, default 4: symbol width; the table holds 2**SYM_WIDTH = 16 entries.
- `CNT_WIDTH`, default 4: width of each per-symbol count.
- `CUM_WIDTH`, default 8: width of cumulative values and totals. The maximum sum is 16×15 = 240, which fits with no overflow.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `counts_unpacked`  in  64: count of symbol i at bits [i*4 +: 4].
- `start`  in  1: request to build the table. Sampled on a rising edge; accepted only when `busy` is 0.
- `busy`  out  1: high while the table is being built.
- `table_vld`  out  1: high once a build has completed. Cleared by reset or by a newly accepted `start`.
- `total_count`  out  8: sum of all snapshot counts. Registered.
- `sym`  in  4: symbol to look up (encoder side).
- `s_count`  out  4: snapshot count of `sym`. Combinational.
- `s_cumulative`  out  8: `cum[sym]`. Combinational.
- `slot`  in  8: slot value to look up (decoder side).
- `slot_sym`  out  4: the symbol whose range [cum, cum+count) contains `slot`. Combinational.
- `slot_err`  out  1: high when `table_vld` is 0 or `slot >= total_count`.

## Operation
- Internal state:
  - `cnt[0..15]` (4 bits each): count snapshot.
  - `cum[0..15]` (8 bits each): cumulative table.
  - `acc` (8 bits): running sum.
  - `idx` (4 bits): build index.
  - FSM with states IDLE, BUILD, DONE.
- Reset: FSM goes to IDLE. All `cnt`, `cum`, `acc`, `idx` and `total_count` are cleared to 0; `busy` = 0 and `table_vld` = 0. Consequently `s_count` = 0, `s_cumulative` = 0, `slot_sym` = 0 and `slot_err` = 1.
- IDLE or DONE with `start` = 1, on the edge:
  - copy all 16 counts from `counts_unpacked` into `cnt`;
  - `acc` ← 0, `idx` ← 0;
  - `table_vld` ← 0, `busy` ← 1;
  - FSM → BUILD.
- BUILD, one entry per cycle:
  - `cum[idx]` ← `acc`;
  - `acc` ← `acc + cnt[idx]`;
  - `idx` ← `idx + 1`.
  - When `idx` = 15, on that same edge: `total_count` ← `acc + cnt[15]`, `busy` ← 0, `table_vld` ← 1, FSM → DONE.
- `start` during BUILD is ignored; there is no queuing.
- `counts_unpacked` is only read on the `start` edge. Later changes have no effect until the next `start`.
- Encoder lookup: `s_count` = `cnt[sym]` and `s_cumulative` = `cum[sym]`. These are pure mux outputs, meaningful when `table_vld` = 1.
- Decoder lookup: `slot_sym` is the unique s with `cnt[s]` ≠ 0 and `cum[s]` ≤ `slot` < `cum[s]` + `cnt[s]`.
  - Zero-count symbols never match.
  - If `slot_err` = 1, `slot_sym` = 0.
- All counts zero: the build completes normally with `total_count` = 0, and `slot_err` stays 1 for every slot.

## Timing
- Start latency: `start` is accepted at edge T0. Then:
  - `busy` = 1 from T0 through T16;
  - `table_vld` = 1 and `total_count` valid after edge T16, i.e. 16 cycles after acceptance.
- Lookups are combinational from `sym`/`slot` and the registered table, with zero latency.
- Restart from DONE drops `table_vld` on the accepting edge. The previous table contents are overwritten progressively during the new build.
- Asynchronous reset mid-BUILD: FSM is immediately in IDLE and all outputs take their reset values. A new `start` is accepted on the first edge after `rst_n` rises.
- `start` held high continuously: the block rebuilds each time it reaches DONE, giving one build every 17 cycles. `table_vld` is high for exactly one cycle per build.

## Test plan
- Reset then idle → `busy` = 0, `table_vld` = 0, `total_count` = 0, `slot_err` = 1 for `slot` = 0.
- Counts: symbol i = 1 for all i. Pulse `start` → `table_vld` rises exactly 16 cycles after acceptance; `total_count` = 16; for `sym` = 9: `s_cumulative` = 9, `s_count` = 1; `slot` = 9 → `slot_sym` = 9; `slot` = 16 → `slot_err` = 1.
- Counts: sym0 = 15, sym3 = 15, sym15 = 2, all others 0 → `total_count` = 32; `cum[3]` = 15, `cum[15]` = 30; `slot` 14 → 0; `slot` 15 → 3; `slot` 29 → 3; `slot` 30 → 15; `slot` 31 → 15; `slot` 32 → `slot_err`.
- All counts = 15 → `total_count` = 240 with no wrap; `cum[15]` = 225; `slot` = 239 → `slot_sym` = 15.
- Pulse `start` mid-build, and change `counts_unpacked` mid-build → both ignored; the result matches the first snapshot. Then restart from DONE → `table_vld` falls on the accepting edge and rises 16 cycles later with the new table.
- Assert `rst_n` low at build cycle 7 → outputs return to reset values immediately. A new `start` after release builds a correct table.
